// File: rtl/io_result_collector_pkg.sv
// io_result_collector_pkg: shared state type, frame header constant and byte-count helper.
package io_result_collector_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    function automatic int bytes_per_word(input int width, input bit header_en);
        return width / 8 + (header_en ? 1 : 0);
    endfunction
endpackage

// File: rtl/io_result_collector_if.sv
// io_result_collector_if: capture strobe/word in, byte stream and FIFO status out.
interface io_result_collector_if #(parameter int WIDTH = 32, parameter int DEPTH = 8);
    logic                     outFlagIOE;
    logic [WIDTH-1:0]         out;
    logic                     clearOverflow;
    logic                     byteReady;
    logic                     byteValid;
    logic [7:0]               byteData;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   count;
    modport master (output outFlagIOE, out, clearOverflow, byteReady,
                    input byteValid, byteData, full, empty, overflow, count);
    modport slave  (input outFlagIOE, out, clearOverflow, byteReady,
                    output byteValid, byteData, full, empty, overflow, count);
endinterface

// File: rtl/io_result_fifo.sv
// io_result_fifo: synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
module io_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    always_ff @(posedge clock)
        if (push) mem[wptr] <= wdata;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    assign rdata = mem[rptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/io_result_collector.sv
// io_result_collector: buffers CPU IO results and serializes them LSB-first as bytes.
// Define IO_RESULT_COLLECTOR_HEADER_EN to prefix every word with FRAME_HEADER.
module io_result_collector
    import io_result_collector_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input logic                  clock,
    input logic                  reset,
    io_result_collector_if.slave bus
);
`ifdef IO_RESULT_COLLECTOR_HEADER_EN
    localparam int BPW = bytes_per_word(WIDTH, 1'b1);
`else
    localparam int BPW = bytes_per_word(WIDTH, 1'b0);
`endif
    localparam int SW = BPW * 8;
    localparam int IW = $clog2(BPW + 1);
    state_t                 state;
    logic [SW-1:0]          sreg, load;
    logic [IW-1:0]          idx;
    logic                   valid, overflow_r, last, pop, push, drop;
    logic [WIDTH-1:0]       fifo_data;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef IO_RESULT_COLLECTOR_HEADER_EN
    assign load = {fifo_data, FRAME_HEADER};
`else
    assign load = fifo_data;
`endif
    assign last = idx == IW'(BPW - 1);
    // Last-byte acceptance reloads directly from the FIFO so words stream without a bubble.
    assign pop  = !fifo_empty && (state == IDLE || (bus.byteReady && last));
    assign push = bus.outFlagIOE && (!fifo_full || pop);
    assign drop = bus.outFlagIOE && fifo_full && !pop;
    io_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock(clock), .reset(reset), .push(push), .wdata(bus.out), .pop(pop),
        .rdata(fifo_data), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            valid      <= 1'b0;
            sreg       <= '0;
            idx        <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (pop) begin
                state <= SEND;
                valid <= 1'b1;
                sreg  <= load;
                idx   <= '0;
            end else if (state == SEND && bus.byteReady) begin
                if (last) begin
                    state <= IDLE;
                    valid <= 1'b0;
                end else begin
                    sreg <= sreg >> 8;
                    idx  <= idx + 1'b1;
                end
            end
            overflow_r <= drop | (overflow_r & ~bus.clearOverflow);
        end
    assign bus.byteValid = valid;
    assign bus.byteData  = sreg[7:0];
    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.overflow  = overflow_r;
    assign bus.count     = fifo_count;
endmodule

// File: tb/tb_io_result_collector.sv
// tb_io_result_collector: directed checks of capture, serialization, backpressure, overflow and reset.
module tb_io_result_collector;
`ifdef IO_RESULT_COLLECTOR_HEADER_EN
    localparam int BPW = 5;
`else
    localparam int BPW = 4;
`endif
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    io_result_collector_if #(.WIDTH(32), .DEPTH(8)) bus ();
    io_result_collector #(.WIDTH(32), .DEPTH(8)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    always #5 clock = ~clock;
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
`ifdef IO_RESULT_COLLECTOR_HEADER_EN
        return i == 0 ? 8'hA5 : w[8*(i-1) +: 8];
`else
        return w[8*i +: 8];
`endif
    endfunction
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drain(input logic [31:0] w, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            chk("byte_valid", 32'(bus.byteValid), 32'd1);
            chk("byte_data", 32'(bus.byteData), 32'(exp_byte(w, i)));
            tick();
        end
    endtask
    initial begin
        bus.outFlagIOE = 1'b0;
        bus.out = '0;
        bus.clearOverflow = 1'b0;
        bus.byteReady = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus.byteValid), 32'd0);
        chk("rst_data", 32'(bus.byteData), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        // single word
        bus.outFlagIOE = 1'b1;
        bus.out = 32'h11223344;
        bus.byteReady = 1'b1;
        tick();
        bus.outFlagIOE = 1'b0;
        chk("cap_empty", 32'(bus.empty), 32'd0);
        chk("cap_count", 32'(bus.count), 32'd1);
        chk("cap_valid", 32'(bus.byteValid), 32'd0);
        tick();
        drain(32'h11223344, 0, BPW);
        chk("single_idle_valid", 32'(bus.byteValid), 32'd0);
        chk("single_empty", 32'(bus.empty), 32'd1);
        chk("idle_hold_data", 32'(bus.byteData), 32'h11);
        // backpressure mid-word
        bus.outFlagIOE = 1'b1;
        bus.out = 32'hCAFEF00D;
        tick();
        bus.outFlagIOE = 1'b0;
        tick();
        tick();
        bus.byteReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.byteValid), 32'd1);
            chk("bp_data", 32'(bus.byteData), 32'(exp_byte(32'hCAFEF00D, 1)));
            tick();
        end
        bus.byteReady = 1'b1;
        drain(32'hCAFEF00D, 1, BPW - 1);
        chk("bp_idle", 32'(bus.byteValid), 32'd0);
        // overflow: one word sits in the shifter, eight fill the FIFO, the next is dropped
        bus.byteReady = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.outFlagIOE = 1'b1;
            bus.out = 32'h0A0B0C00 + 32'(k);
            tick();
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd8);
        chk("fill_ovf", 32'(bus.overflow), 32'd0);
        bus.out = 32'h0A0B0C09;
        tick();
        chk("drop_ovf", 32'(bus.overflow), 32'd1);
        chk("drop_count", 32'(bus.count), 32'd8);
        chk("drop_frozen", 32'(bus.byteData), 32'(exp_byte(32'h0A0B0C00, 0)));
        bus.out = 32'h0A0B0C0A;
        bus.clearOverflow = 1'b1;
        tick();
        chk("set_wins", 32'(bus.overflow), 32'd1);
        bus.outFlagIOE = 1'b0;
        tick();
        bus.clearOverflow = 1'b0;
        chk("ovf_clear", 32'(bus.overflow), 32'd0);
        // full with simultaneous push and pop
        bus.byteReady = 1'b1;
        drain(32'h0A0B0C00, 0, BPW - 1);
        chk("last_w0", 32'(bus.byteData), 32'(exp_byte(32'h0A0B0C00, BPW - 1)));
        bus.outFlagIOE = 1'b1;
        bus.out = 32'h55667788;
        tick();
        bus.outFlagIOE = 1'b0;
        chk("pp_count", 32'(bus.count), 32'd8);
        chk("pp_full", 32'(bus.full), 32'd1);
        chk("pp_ovf", 32'(bus.overflow), 32'd0);
        for (int k = 1; k < 9; k++) drain(32'h0A0B0C00 + 32'(k), 0, BPW);
        drain(32'h55667788, 0, BPW);
        chk("drain_valid", 32'(bus.byteValid), 32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_count", 32'(bus.count), 32'd0);
        // reset mid-word
        bus.outFlagIOE = 1'b1;
        bus.out = 32'h01020304;
        tick();
        bus.outFlagIOE = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mr_valid", 32'(bus.byteValid), 32'd0);
        chk("mr_empty", 32'(bus.empty), 32'd1);
        chk("mr_count", 32'(bus.count), 32'd0);
        chk("mr_data", 32'(bus.byteData), 32'd0);
        tick();
        reset = 1'b1;
        bus.outFlagIOE = 1'b1;
        bus.out = 32'hDEADBEEF;
        tick();
        bus.outFlagIOE = 1'b0;
        tick();
        drain(32'hDEADBEEF, 0, BPW);
        chk("post_reset_idle", 32'(bus.byteValid), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
